// File: rtl/prog_loader_if.sv
// Boot-loader bus: UART RX/TX buffer handshake, program RAM write port and core release.
interface prog_loader_if #(
   parameter int MEM = 17
);
   logic [7:0]     rdata;
   logic           rx_ready;
   logic           next;
   logic [7:0]     sdata;
   logic           tx_ready;
   logic           prog_we;
   logic [MEM-3:0] prog_addr;
   logic [31:0]    prog_din;
   logic           core_rstn;
   logic           done;

   modport master (
      input  rdata, rx_ready,
      output next, sdata, tx_ready, prog_we, prog_addr, prog_din, core_rstn, done
   );

   modport slave (
      output rdata, rx_ready,
      input  next, sdata, tx_ready, prog_we, prog_addr, prog_din, core_rstn, done
   );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: receives a length-prefixed little-endian image over UART bytes, writes it
// word by word into program RAM, sends an acknowledge byte and then releases the core.
module prog_loader #(
   parameter int         MEM      = 17,
   parameter logic [7:0] ACK_BYTE = 8'hAA
) (
   input logic          clk,
   input logic          rstn,
   prog_loader_if.master bus
);

   typedef enum logic [1:0] {S_LEN, S_DATA, S_ACK, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     bcnt_q, bcnt_d;
   logic [31:0]    wcnt_q, wcnt_d;
   logic [31:0]    len_q, len_d;
   logic [31:0]    word_q, word_d;
   logic           next_q, next_d;
   logic           tx_q, tx_d;
   logic [7:0]     sdata_q, sdata_d;
   logic           we_q, we_d;
   logic [MEM-3:0] addr_q, addr_d;
   logic [31:0]    din_q, din_d;
   logic           done_q, done_d;
   logic           pop;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_LEN;
         bcnt_q  <= '0;
         wcnt_q  <= '0;
         len_q   <= '0;
         word_q  <= '0;
         next_q  <= 1'b0;
         tx_q    <= 1'b0;
         sdata_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         wcnt_q  <= wcnt_d;
         len_q   <= len_d;
         word_q  <= word_d;
         next_q  <= next_d;
         tx_q    <= tx_d;
         sdata_q <= sdata_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      wcnt_d  = wcnt_q;
      len_d   = len_q;
      word_d  = word_q;
      next_d  = 1'b0;
      tx_d    = 1'b0;
      sdata_d = sdata_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      done_d  = done_q;
      // The cycle after a pop the RX head is still stale, so skip it.
      pop = bus.rx_ready && !next_q && (state_q == S_LEN || state_q == S_DATA);

      case (state_q)
         S_LEN: begin
            if (pop) begin
               next_d = 1'b1;
               bcnt_d = bcnt_q + 2'd1;
               len_d[{bcnt_q, 3'b000} +: 8] = bus.rdata;
               if (bcnt_q == 2'd3) begin
                  wcnt_d  = '0;
                  state_d = (len_d == 32'd0) ? S_ACK : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (pop) begin
               next_d = 1'b1;
               bcnt_d = bcnt_q + 2'd1;
               word_d[{bcnt_q, 3'b000} +: 8] = bus.rdata;
               if (bcnt_q == 2'd3) begin
                  we_d   = 1'b1;
                  addr_d = wcnt_q[MEM-3:0];
                  din_d  = word_d;
                  wcnt_d = wcnt_q + 32'd1;
                  if (wcnt_q + 32'd1 == len_q) state_d = S_ACK;
               end
            end
         end
         S_ACK: begin
            tx_d    = 1'b1;
            sdata_d = ACK_BYTE;
            state_d = S_DONE;
         end
         S_DONE: done_d = 1'b1;
         default: state_d = S_LEN;
      endcase
   end

   assign bus.next      = next_q;
   assign bus.tx_ready  = tx_q;
   assign bus.sdata     = sdata_q;
   assign bus.prog_we   = we_q;
   assign bus.prog_addr = addr_q;
   assign bus.prog_din  = din_q;
   assign bus.done      = done_q;
   assign bus.core_rstn = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a MEM=17 and a MEM=4 instance share one byte stream and are
// scored against an image-level model of the expected RAM writes, ack and release.
module tb_prog_loader;
   typedef int unsigned uq_t[$];

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] rdata = 8'h00;
   logic       rx_ready = 1'b0;

   always #5 clk = ~clk;

   prog_loader_if #(.MEM(17)) b17();
   prog_loader_if #(.MEM(4))  b4();

   assign b17.rdata = rdata;
   assign b17.rx_ready = rx_ready;
   assign b4.rdata = rdata;
   assign b4.rx_ready = rx_ready;

   prog_loader #(.MEM(17)) d17 (.clk(clk), .rstn(rstn), .bus(b17.master));
   prog_loader #(.MEM(4))  d4  (.clk(clk), .rstn(rstn), .bus(b4.master));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   uq_t wa0, wd0, wa1, wd1;
   int npop[2] = '{0, 0};
   int ntx[2] = '{0, 0};
   int nviol[2] = '{0, 0};
   int we_c[2] = '{0, 0};
   int tx_c[2] = '{0, 0};
   int dn_c[2] = '{0, 0};
   logic [7:0] lsd[2] = '{8'h00, 8'h00};
   logic pn[2] = '{1'b0, 1'b0};
   logic pw[2] = '{1'b0, 1'b0};
   logic pd[2] = '{1'b0, 1'b0};
   int s_we[2], s_pop[2], s_tx[2], s_viol[2];
   int s_cyc;
   logic [7:0] stream[$];

   // Protocol watcher: records writes/acks and counts pop/write spacing violations.
   function automatic void mon(input int k, input logic nx, input logic we, input logic tx,
                               input logic dn, input logic cr, input logic [31:0] ad,
                               input logic [31:0] dt, input logic [7:0] sd);
      if (we) begin
         if (k == 0) begin wa0.push_back(ad); wd0.push_back(dt); end
         else        begin wa1.push_back(ad); wd1.push_back(dt); end
         we_c[k] = cyc;
      end
      if (nx) npop[k]++;
      if (nx && (!rx_ready || pn[k])) nviol[k]++;
      if (we && pw[k]) nviol[k]++;
      if (cr !== dn) nviol[k]++;
      if (tx) begin ntx[k]++; lsd[k] = sd; tx_c[k] = cyc; end
      if (dn && !pd[k]) dn_c[k] = cyc;
      pn[k] = nx; pw[k] = we; pd[k] = dn;
   endfunction

   always @(negedge clk) begin
      cyc++;
      mon(0, b17.next, b17.prog_we, b17.tx_ready, b17.done, b17.core_rstn,
          32'(b17.prog_addr), b17.prog_din, b17.sdata);
      mon(1, b4.next, b4.prog_we, b4.tx_ready, b4.done, b4.core_rstn,
          32'(b4.prog_addr), b4.prog_din, b4.sdata);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_we[0] = wa0.size(); s_we[1] = wa1.size();
      for (int k = 0; k < 2; k++) begin
         s_pop[k] = npop[k]; s_tx[k] = ntx[k]; s_viol[k] = nviol[k];
      end
      s_cyc = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   // RX buffer stand-in: presents stream head, pops on each next pulse, optional random gaps.
   task automatic run_stream(input bit gappy, input int maxpops);
      int idx = 0, pops = 0, gap = 0, budget = 0;
      bit popping;
      if (gappy) gap = $urandom_range(0, 30);
      while (idx < stream.size() && pops < maxpops && budget < 5000) begin
         rx_ready = (gap == 0);
         rdata = stream[idx];
         @(negedge clk);
         popping = b17.next;
         @(posedge clk);
         #1;
         if (popping) begin
            idx++; pops++;
            gap = gappy ? $urandom_range(0, 30) : 0;
         end else if (gap > 0) gap--;
         budget++;
      end
      rx_ready = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && !(b17.done && b4.done); i++) @(negedge clk);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl17"}, {27'd0, b17.next, b17.tx_ready, b17.prog_we, b17.core_rstn, b17.done}, 32'd0);
      chk({tag, "_sd17"}, {24'd0, b17.sdata}, 32'd0);
      chk({tag, "_ad17"}, 32'(b17.prog_addr), 32'd0);
      chk({tag, "_din17"}, b17.prog_din, 32'd0);
      chk({tag, "_ctl4"}, {27'd0, b4.next, b4.tx_ready, b4.prog_we, b4.core_rstn, b4.done}, 32'd0);
      chk({tag, "_sd4"}, {24'd0, b4.sdata}, 32'd0);
      chk({tag, "_ad4"}, 32'(b4.prog_addr), 32'd0);
      chk({tag, "_din4"}, b4.prog_din, 32'd0);
   endtask

   // Reference: N words follow the 4-byte length; word i lands at i mod RAM depth.
   task automatic check_dut(input string tag, input int k, input int mem,
                            input uq_t wa, input uq_t wd, input logic dn, input logic cr);
      int n, nw;
      int unsigned ea, ed;
      n = int'({stream[3], stream[2], stream[1], stream[0]});
      nw = wa.size() - s_we[k];
      chk({tag, "_nwr"}, nw, n);
      for (int i = 0; i < n && i < nw; i++) begin
         ea = i % (1 << (mem - 2));
         ed = {stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]};
         chk({tag, "_addr"}, wa[s_we[k]+i], ea);
         chk({tag, "_data"}, wd[s_we[k]+i], ed);
      end
      chk({tag, "_pops"}, npop[k] - s_pop[k], 4 + 4 * n);
      chk({tag, "_ntx"}, ntx[k] - s_tx[k], 1);
      chk({tag, "_sdata"}, {24'd0, lsd[k]}, 32'h0000_00AA);
      chk({tag, "_done"}, {31'd0, dn}, 32'd1);
      chk({tag, "_corerst"}, {31'd0, cr}, 32'd1);
      chk({tag, "_viol"}, nviol[k] - s_viol[k], 0);
      chk({tag, "_tx2done"}, dn_c[k] - tx_c[k], 1);
      if (n > 0) chk({tag, "_we2tx"}, tx_c[k] - we_c[k], 1);
   endtask

   task automatic load(input string tag, input bit gappy);
      snap();
      run_stream(gappy, 1000);
      wait_done();
      check_dut({tag, "17"}, 0, 17, wa0, wd0, b17.done, b17.core_rstn);
      check_dut({tag, "4"}, 1, 4, wa1, wd1, b4.done, b4.core_rstn);
   endtask

   initial begin
      int n;
      logic [31:0] w;
      // Reset held with data pending: nothing may move.
      rx_ready = 1'b1;
      rdata = 8'h55;
      repeat (3) @(negedge clk);
      check_zero("rst");
      rx_ready = 1'b0;
      rstn = 1'b1;
      snap();
      repeat (20) @(negedge clk);
      chk("idle_pops17", npop[0] - s_pop[0], 0);
      chk("idle_pops4", npop[1] - s_pop[1], 0);
      chk("idle_core", {30'd0, b17.core_rstn, b4.core_rstn}, 32'd0);
      chk("idle_done", {30'd0, b17.done, b4.done}, 32'd0);

      stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00};
      load("two", 1'b0);

      do_reset();
      stream = '{8'h00, 8'h00, 8'h00, 8'h00};
      load("zero", 1'b0);

      do_reset();
      stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00};
      load("gappy", 1'b1);

      // Abort mid-load between clock edges, then a fresh image must complete.
      do_reset();
      snap();
      run_stream(1'b0, 6);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1 check_zero("midrst");
      chk("midrst_nwr", wa0.size() - s_we[0], 0);
      @(negedge clk);
      rstn = 1'b1;
      stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      load("after", 1'b0);

      do_reset();
      stream = '{8'h05, 8'h00, 8'h00, 8'h00};
      for (int i = 1; i <= 5; i++) begin
         stream.push_back(8'(i)); stream.push_back(8'h00);
         stream.push_back(8'h00); stream.push_back(8'h00);
      end
      load("wrap", 1'b0);

      for (int t = 0; t < 3; t++) begin
         do_reset();
         n = $urandom_range(1, 6);
         stream = '{8'(n), 8'h00, 8'h00, 8'h00};
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
         end
         load("rand", 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader between uart_rx_with_buf/uart_tx_with_buf and program memory.
- Holds the core in reset, receives a length-prefixed little-endian program image over UART bytes, assembles 32-bit words and writes them sequentially into program RAM.
- When the image is complete it sends a one-byte acknowledge and releases the core.

Parameters:
- MEM, 17, byte-address width of memory space; program RAM word-address width is MEM-2.
- ACK_BYTE, 8'hAA, byte transmitted after the last word is written.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- rdata  input  8  head byte of RX buffer, valid while rx_ready=1
- rx_ready  input  1  RX buffer non-empty
- next  output  1  one-cycle pop strobe to RX buffer
- sdata  output  8  byte to transmit
- tx_ready  output  1  one-cycle send strobe to TX buffer
- prog_we  output  1  program RAM write enable
- prog_addr  output  MEM-2  program RAM word address
- prog_din  output  32  program RAM write data
- core_rstn  output  1  active-low reset to core; 0 until load completes
- done  output  1  load complete

Behaviour:
- Interface: one clock `clk`; reset `rstn` asynchronous, active-low.
- Reset values: next=0, tx_ready=0, sdata=0, prog_we=0, prog_addr=0, prog_din=0, core_rstn=0, done=0. State=LEN, byte counter=0, word counter=0, length=0.
- Assertion of rstn at any point, including mid-load, aborts immediately to these values. Partially written RAM contents are not cleared; the next load overwrites them.
- Byte consumption: in LEN or DATA, when rx_ready=1 and no pop was issued in the previous cycle, capture rdata and pulse next for exactly one cycle. Pops are therefore spaced at least 2 cycles apart, so the RX buffer can update its head. rx_ready is ignored in all other states.
- States:
  - LEN: collect 4 bytes, little-endian (first byte = bits 7:0), into 32-bit length N in words. After the 4th byte:
    - N=0 goes to ACK.
    - Otherwise goes to DATA with word counter=0.
  - DATA: collect 4 bytes little-endian into a word. In the cycle after the 4th byte is captured, prog_we=1 for one cycle, with prog_addr = word counter[MEM-3:0] and prog_din = assembled word. The word counter then increments.
    - After the write of word N-1, go to ACK.
    - prog_we is never high in two consecutive cycles.
  - ACK: for one cycle, tx_ready=1 and sdata=ACK_BYTE. Then go to DONE.
  - DONE: done=1 and core_rstn=1 from the first DONE cycle, held until rstn. No further pops or writes.
- Width and wrap rules:
  - Word counter is 32 bits; prog_addr is its low MEM-2 bits. If N > 2^(MEM-2), addresses wrap and later words overwrite earlier ones.
  - Byte counter is 2 bits and wraps 3→0.
- prog_din and prog_addr hold their last values when prog_we=0.
- Latency: from capture of a word's 4th byte to prog_we = 1 cycle. From the last write to tx_ready = 1 cycle. From tx_ready to done/core_rstn = 1 cycle.

Test Plan:
- Reset mid-stream: hold rstn=0 and check all outputs are 0. Release; with rx_ready=0 for 20 cycles, expect no next pulses, state LEN, core_rstn=0.
- Two-word load: bytes 02 00 00 00, 13 05 A0 00, 6F 00 00 00 back-to-back with rx_ready always 1. Expect:
  - exactly 12 next pulses, each separated by ≥1 idle cycle;
  - prog_we at addr 0 with data 32'h00A00513, then at addr 1 with data 32'h0000006F;
  - one tx_ready with sdata=8'hAA, then done=1 and core_rstn=1.
- Zero length: bytes 00 00 00 00. Expect no prog_we, tx_ready with sdata=8'hAA, then done=1.
- Gappy RX: same image as the two-word load, with rx_ready deasserted for random 0–30 cycle gaps between bytes. Expect identical writes and ack; next only ever high while rx_ready=1.
- Reset mid-load: apply rstn low after 6 bytes of the two-word image. Expect:
  - outputs reset asynchronously;
  - a subsequent full one-word image (01 00 00 00, 78 56 34 12) writes 32'h12345678 to addr 0 and completes.
- Wrap: with MEM=4 (RAM depth 4), load N=5 with words 1..5. Expect addresses 0,1,2,3,0, with the final write to addr 0 carrying 32'h5, then ack and done.
